// File: rtl/mc_pkg.sv
// mc_pkg: shared state encodings, opcode/funct constants and select codes for the multi-cycle controller.
package mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: R-type funct to ALU operation, flagging unsupported funct codes.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_legal
);
    always_comb begin
        alucontrol  = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_main_controller.sv
// mc_main_controller: Moore FSM sequencing the multi-cycle MIPS datapath.
// Define MC_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR until mem_ready.
module mc_main_controller
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcen,
    output logic               irwrite,
    output logic               memwrite,
    output logic               regwrite,
    output logic               iord,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic               regdst,
    output logic               memtoreg,
    output logic [2:0]         alucontrol,
    output logic               retire,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);
    state_t     state, state_nx;
    logic       ready, pcwrite, branch, irw, mw, rw, ret;
    logic       funct_legal, op_legal;
    logic [2:0] fn_alu;
`ifdef MC_MEM_WAIT_EN
    assign ready = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign ready = 1'b1;
`endif
    mc_alu_decoder u_alu_decoder (
        .funct       (funct),
        .alucontrol  (fn_alu),
        .funct_legal (funct_legal)
    );
    assign op_legal = (opcode inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}) ||
                      (opcode == OP_RTYPE && funct_legal);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            illegal_op <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE && !op_legal) illegal_op <= 1'b1;
        end
    end
    always_comb begin
        state_nx   = S_FETCH;
        irw        = 1'b0;
        mw         = 1'b0;
        rw         = 1'b0;
        ret        = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REGB;
        pcsrc      = PC_ALU;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alucontrol = ALU_ADD;
        case (state)
            S_FETCH: begin
                alusrcb  = SRCB_FOUR;
                irw      = ready;
                pcwrite  = ready;
                state_nx = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMM2;
                case (opcode)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = funct_legal ? S_EXECUTE : S_FETCH;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_ADDI:      state_nx = S_ADDIEX;
                    OP_J:         state_nx = S_JUMP;
                    default:      state_nx = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca  = 1'b1;
                alusrcb  = SRCB_IMM;
                state_nx = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                state_nx = ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                rw       = 1'b1;
                ret      = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                mw       = ready;
                ret      = ready;
                state_nx = ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = fn_alu;
                state_nx   = S_ALUWB;
            end
            S_ALUWB: begin
                regdst = 1'b1;
                rw     = 1'b1;
                ret    = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = PC_ALUOUT;
                branch     = 1'b1;
                ret        = 1'b1;
            end
            S_ADDIEX: begin
                alusrca  = 1'b1;
                alusrcb  = SRCB_IMM;
                state_nx = S_ADDIWB;
            end
            S_ADDIWB: begin
                rw  = 1'b1;
                ret = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = PC_JUMP;
                pcwrite = 1'b1;
                ret     = 1'b1;
            end
            default: state_nx = S_FETCH;
        endcase
    end
    // Enables are gated by reset so nothing can write while reset is held.
    assign pcen      = reset & (pcwrite | (branch & zero));
    assign irwrite   = reset & irw;
    assign memwrite  = reset & mw;
    assign regwrite  = reset & rw;
    assign retire    = reset & ret;
    assign state_dbg = STATE_W'(state);
endmodule

// File: tb/tb_mc_main_controller.sv
// tb_mc_main_controller: scoreboard bench; per-cycle expected outputs queued, then compared each cycle.
module tb_mc_main_controller;
    typedef struct packed {
        logic [3:0] st;
        logic       pcen, irwrite, memwrite, regwrite, retire, iord, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic       regdst, memtoreg;
        logic [2:0] aluc;
        logic       ill;
    } exp_t;
    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       pcen, irwrite, memwrite, regwrite, iord, alusrca, regdst, memtoreg, retire, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_dbg;
    exp_t       o;
    exp_t       q[$];
    string      tq[$];
    int         errors = 0;
    int         checks = 0;
    logic       ill_exp = 1'b0;
    mc_main_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite),
        .regwrite(regwrite), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg), .alucontrol(alucontrol),
        .retire(retire), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );
    always #5 clk = ~clk;
    assign o = {state_dbg, pcen, irwrite, memwrite, regwrite, retire, iord, alusrca,
                alusrcb, pcsrc, regdst, memtoreg, alucontrol, illegal_op};
    function automatic exp_t mk(int st, logic z, logic rdy, logic ill, logic [2:0] a);
        exp_t e;
        logic pw, br;
        e = '0;
        e.st = st[3:0];
        e.aluc = 3'b010;
        e.ill = ill;
        pw = 1'b0;
        br = 1'b0;
        case (st)
            0: begin e.irwrite = rdy; pw = rdy; e.alusrcb = 2'b01; end
            1: e.alusrcb = 2'b11;
            2: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            3: e.iord = 1'b1;
            4: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; e.retire = 1'b1; end
            5: begin e.iord = 1'b1; e.memwrite = rdy; e.retire = rdy; end
            6: begin e.alusrca = 1'b1; e.aluc = a; end
            7: begin e.regdst = 1'b1; e.regwrite = 1'b1; e.retire = 1'b1; end
            8: begin e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01; br = 1'b1; e.retire = 1'b1; end
            9: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            10: begin e.regwrite = 1'b1; e.retire = 1'b1; end
            11: begin e.pcsrc = 2'b10; pw = 1'b1; e.retire = 1'b1; end
            default: ;
        endcase
        e.pcen = pw | (br & z);
        return e;
    endfunction
    task automatic p(input string t, input int st, input logic [2:0] a = 3'b010, input logic rdy = 1'b1);
        q.push_back(mk(st, zero, rdy, ill_exp, a));
        tq.push_back(t);
    endtask
    task automatic p_rst(input string t);
        exp_t e;
        e = '0;
        e.aluc = 3'b010;
        e.alusrcb = 2'b01;
        q.push_back(e);
        tq.push_back(t);
    endtask
    task automatic check1();
        exp_t e;
        string t;
        #1;
        e = q.pop_front();
        t = tq.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", t, o, e);
        end
    endtask
    task automatic drain();
        while (q.size() > 0) begin
            check1();
            @(negedge clk);
        end
    endtask
    initial begin
        reset = 1'b0;
        zero = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'b000000;
        funct = 6'b100000;
        @(negedge clk);
        p_rst("rst0"); p_rst("rst1"); p_rst("rst2");
        drain();
        reset = 1'b1;
        p("add_f", 0); p("add_d", 1); p("add_ex", 6, 3'b010); p("add_wb", 7);
        drain();
        funct = 6'b100010;
        p("sub_f", 0); p("sub_d", 1); p("sub_ex", 6, 3'b110); p("sub_wb", 7);
        drain();
        funct = 6'b101010;
        p("slt_f", 0); p("slt_d", 1); p("slt_ex", 6, 3'b111); p("slt_wb", 7);
        drain();
        opcode = 6'b100011;
        p("lw_f", 0); p("lw_d", 1); p("lw_ma", 2); p("lw_rd", 3); p("lw_wb", 4);
        drain();
        opcode = 6'b101011;
        p("sw_f", 0); p("sw_d", 1); p("sw_ma", 2); p("sw_wr", 5);
        drain();
        opcode = 6'b000100;
        zero = 1'b1;
        p("beq1_f", 0); p("beq1_d", 1); p("beq1_br", 8);
        drain();
        zero = 1'b0;
        p("beq0_f", 0); p("beq0_d", 1); p("beq0_br", 8);
        drain();
        opcode = 6'b001000;
        p("addi_f", 0); p("addi_d", 1); p("addi_ex", 9); p("addi_wb", 10);
        drain();
        opcode = 6'b000010;
        p("j_f", 0); p("j_d", 1); p("j_j", 11);
        drain();
`ifdef MC_MEM_WAIT_EN
        opcode = 6'b101011;
        mem_ready = 1'b0;
        p("wait_f0", 0, 3'b010, 1'b0);
        check1();
        @(negedge clk);
        p("wait_f1", 0, 3'b010, 1'b0);
        check1();
        @(negedge clk);
        mem_ready = 1'b1;
        p("wait_f2", 0); p("wait_d", 1); p("wait_ma", 2); p("wait_wr", 5);
        drain();
`endif
        opcode = 6'b000000;
        funct = 6'b000111;
        p("badfn_f", 0); p("badfn_d", 1);
        drain();
        ill_exp = 1'b1;
        opcode = 6'b100011;
        p("midlw_f", 0); p("midlw_d", 1); p("midlw_ma", 2);
        drain();
        p("midlw_rd", 3);
        check1();
        reset = 1'b0;
        ill_exp = 1'b0;
        p_rst("midlw_rst");
        check1();
        @(negedge clk);
        p_rst("midlw_rst_hold");
        check1();
        reset = 1'b1;
        opcode = 6'b111111;
        p("badop_f", 0); p("badop_d", 1);
        drain();
        ill_exp = 1'b1;
        p("badop_refetch", 0); p("badop_d2", 1);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
